sevenseg_capture: RTL and testbench
===================================

SEVENSEG_CAPTURE -- requirements
Module: sevenseg_capture

Interface
REQ-001 Parameter SETTLE, default 4: cycles to ignore seg after a display-phase change.
REQ-002 Parameter STABLE, default 3: consecutive identical legal samples needed to commit a digit.
REQ-003 The block SHALL have exactly one clock; reset is asynchronous and active-low.
REQ-004 clk  input  1  sole clock, rising edge.
REQ-005 reset_n  input  1  asynchronous active-low reset.
REQ-006 enable1  input  1  display enable 1, asynchronous to clk.
REQ-007 enable2  input  1  display enable 2, asynchronous to clk.
REQ-008 seg  input  7  segments gfedcba, active-low (common anode), asynchronous to clk.
REQ-009 segerr_clr  input  1  synchronous clear of segerr.
REQ-010 digit1  output  4  last committed digit for phase P1.
REQ-011 digit2  output  4  last committed digit for phase P2.
REQ-012 valid1, valid2  output  1 each  digit1/digit2 committed at least once since reset.
REQ-013 update  output  1  one-cycle pulse when a committed digit changes value or first becomes valid.
REQ-014 update_sel  output  1  during update: 0 = digit1 written, 1 = digit2 written.
REQ-015 segerr  output  1  sticky flag: an illegal pattern was sampled.

Function
REQ-016 enable1, enable2 and seg SHALL each pass through a 2-flop synchronizer; all following timing counts from the synchronized values.
REQ-017 Phase decode:
- enable2=1, enable1=0: P1 (digit1 shown).
- enable1=1, enable2=0: P2 (digit2 shown).
- Both enables equal: NONE.
REQ-018 The block SHALL use the FSM states IDLE, SETTLE, SAMPLE and HOLD, plus a registered current phase.
REQ-019 In any state, a synchronized phase that differs from the registered phase SHALL update the registered phase, clear both counters, and go to SETTLE (P1/P2) or IDLE (NONE) on the next cycle.
REQ-020 SETTLE: seg is ignored for SETTLE cycles; the FSM then enters SAMPLE with the match count at 0.
REQ-021 SAMPLE: one seg sample per cycle, decoded through the table 0=40 1=79 2=24 3=30 4=19 5=12 6=02 7=78 8=00 9=18 A=08 B=03 C=27 D=21 E=06 F=0E (hex of seg).
REQ-022 A legal sample equal to the previous legal sample SHALL increment the match count; any other legal sample SHALL set the count to 1.
REQ-023 An illegal sample (any pattern not in the table, including 7F blank) SHALL set segerr and clear the match count.
REQ-024 When the count reaches STABLE, the value SHALL be committed to the current phase's digit, valid SHALL be set, and the FSM enters HOLD.
- Commit happens at most once per phase interval.
REQ-025 update SHALL pulse for exactly one cycle, registered, in the cycle after the commit edge, but only if the committed value differs from the stored digit or valid was 0.
- update_sel SHALL identify the written digit during that pulse.
REQ-026 HOLD: seg is ignored until the phase changes.
REQ-027 A phase change before commit SHALL discard the partial sample; stored digits are untouched.
REQ-028 NONE/IDLE SHALL retain digits and valid flags indefinitely.
REQ-029 segerr_clr SHALL clear segerr; if it coincides with an illegal sample, segerr SHALL remain 1 (set wins).
REQ-030 The match counter SHALL saturate at STABLE and never wrap; the settle counter SHALL be sized for SETTLE with no overflow.

Reset
REQ-031 reset_n=0 SHALL asynchronously force:
- FSM to IDLE, registered phase to NONE, counters and synchronizers to 0.
- digit1=digit2=0, valid1=valid2=0, update=0, update_sel=0, segerr=0.
REQ-032 Reset deassertion mid-display SHALL be treated as a phase change from NONE.
- No commit until a full SETTLE plus STABLE samples have elapsed.

Verification
REQ-033 P1 held, seg=30 steady, SETTLE=4, STABLE=3 -> digit1=3, valid1=1, one update pulse with update_sel=0; digit2/valid2 unchanged.
REQ-034 Alternating P1 (seg=19) / P2 (seg=0E), 64 cycles each -> digit1=4, digit2=F, exactly one update per digit, then no further updates.
REQ-035 P2 with seg=24 for only 2 samples, then phase goes to NONE -> no commit, no update, valid2 stays 0.
REQ-036 P1 with seg=7F during SAMPLE -> segerr=1 and no commit; segerr_clr pulse -> segerr=0.
REQ-037 P1 with seg glitching 02,02,00,02,02,02 -> commit 6 only after the last three consecutive 02 samples.
REQ-038 reset_n pulsed low mid-SAMPLE with digit1=9 stored -> all outputs 0 immediately; after release, recapture within 2+SETTLE+STABLE+1 cycles of steady input.

Source files
------------

// File: rtl/sevenseg_capture.sv
// Seven-segment display capture: recovers two multiplexed hex digits.
// Ports: clk, reset_n, enable1/enable2/seg (async), segerr_clr; digit1/2, valid1/2, update, update_sel, segerr.
module sevenseg_capture #(
    parameter int SETTLE = 4,
    parameter int STABLE = 3
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       enable1,
    input  logic       enable2,
    input  logic [6:0] seg,
    input  logic       segerr_clr,
    output logic [3:0] digit1,
    output logic [3:0] digit2,
    output logic       valid1,
    output logic       valid2,
    output logic       update,
    output logic       update_sel,
    output logic       segerr
);

    localparam int SW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
    localparam int MW = (STABLE > 1) ? $clog2(STABLE + 1) : 1;

    localparam logic [SW-1:0] SETTLE_LAST = SW'(SETTLE - 1);
    localparam logic [MW-1:0] STABLE_C    = MW'(STABLE);

    localparam logic [1:0] PH_NONE = 2'd0;
    localparam logic [1:0] PH_P1   = 2'd1;
    localparam logic [1:0] PH_P2   = 2'd2;

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_SETTLE = 2'd1;
    localparam logic [1:0] S_SAMPLE = 2'd2;
    localparam logic [1:0] S_HOLD   = 2'd3;

    logic          en1_s1, en1_s2;
    logic          en2_s1, en2_s2;
    logic [6:0]    seg_s1, seg_s2;

    logic [1:0]    state;
    logic [1:0]    phase;
    logic [SW-1:0] settle_cnt;
    logic [MW-1:0] match_cnt;
    logic [3:0]    last_val;

    logic [1:0]    sync_phase;
    logic          phase_chg;
    logic [3:0]    seg_val;
    logic          seg_legal;
    logic [MW-1:0] match_next;
    logic          sampling;
    logic          bad;
    logic          hit;
    logic          commit;

    // Two-flop synchronizers on all display inputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            en1_s1 <= 1'b0;
            en1_s2 <= 1'b0;
            en2_s1 <= 1'b0;
            en2_s2 <= 1'b0;
            seg_s1 <= '0;
            seg_s2 <= '0;
        end else begin
            en1_s1 <= enable1;
            en1_s2 <= en1_s1;
            en2_s1 <= enable2;
            en2_s2 <= en2_s1;
            seg_s1 <= seg;
            seg_s2 <= seg_s1;
        end
    end

    always_comb begin
        sync_phase = PH_NONE;
        if (en2_s2 && !en1_s2) begin
            sync_phase = PH_P1;
        end else if (en1_s2 && !en2_s2) begin
            sync_phase = PH_P2;
        end
    end

    // Active-low gfedcba patterns; anything else, blank included, is illegal.
    always_comb begin
        seg_val   = 4'h0;
        seg_legal = 1'b1;
        case (seg_s2)
            7'h40:   seg_val = 4'h0;
            7'h79:   seg_val = 4'h1;
            7'h24:   seg_val = 4'h2;
            7'h30:   seg_val = 4'h3;
            7'h19:   seg_val = 4'h4;
            7'h12:   seg_val = 4'h5;
            7'h02:   seg_val = 4'h6;
            7'h78:   seg_val = 4'h7;
            7'h00:   seg_val = 4'h8;
            7'h18:   seg_val = 4'h9;
            7'h08:   seg_val = 4'hA;
            7'h03:   seg_val = 4'hB;
            7'h27:   seg_val = 4'hC;
            7'h21:   seg_val = 4'hD;
            7'h06:   seg_val = 4'hE;
            7'h0E:   seg_val = 4'hF;
            default: seg_legal = 1'b0;
        endcase
    end

    // A zero count means no previous legal sample in the current run.
    always_comb begin
        match_next = MW'(1);
        if (match_cnt != '0 && seg_val == last_val) begin
            if (match_cnt == STABLE_C) begin
                match_next = match_cnt;
            end else begin
                match_next = match_cnt + 1'b1;
            end
        end
    end

    assign phase_chg = (sync_phase != phase);
    assign sampling  = (state == S_SAMPLE) && !phase_chg;
    assign bad       = sampling && !seg_legal;
    assign hit       = (match_next == STABLE_C);
    assign commit    = sampling && seg_legal && hit;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= S_IDLE;
            phase      <= PH_NONE;
            settle_cnt <= '0;
            match_cnt  <= '0;
            last_val   <= 4'h0;
        end else if (phase_chg) begin
            phase      <= sync_phase;
            settle_cnt <= '0;
            match_cnt  <= '0;
            state      <= (sync_phase == PH_NONE) ? S_IDLE : S_SETTLE;
        end else begin
            case (state)
                S_SETTLE: begin
                    if (settle_cnt == SETTLE_LAST) begin
                        state      <= S_SAMPLE;
                        settle_cnt <= '0;
                        match_cnt  <= '0;
                    end else begin
                        settle_cnt <= settle_cnt + 1'b1;
                    end
                end
                S_SAMPLE: begin
                    if (!seg_legal) begin
                        match_cnt <= '0;
                    end else begin
                        match_cnt <= match_next;
                        last_val  <= seg_val;
                        if (hit) begin
                            state <= S_HOLD;
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Digit storage and the registered update strobe.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            digit1     <= 4'h0;
            digit2     <= 4'h0;
            valid1     <= 1'b0;
            valid2     <= 1'b0;
            update     <= 1'b0;
            update_sel <= 1'b0;
        end else begin
            update <= 1'b0;
            if (commit) begin
                update_sel <= (phase == PH_P2);
                if (phase == PH_P2) begin
                    digit2 <= seg_val;
                    valid2 <= 1'b1;
                    update <= (seg_val != digit2) || !valid2;
                end else begin
                    digit1 <= seg_val;
                    valid1 <= 1'b1;
                    update <= (seg_val != digit1) || !valid1;
                end
            end
        end
    end

    // A fresh illegal sample beats a simultaneous clear.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            segerr <= 1'b0;
        end else if (bad) begin
            segerr <= 1'b1;
        end else if (segerr_clr) begin
            segerr <= 1'b0;
        end
    end

endmodule

// File: tb/tb_sevenseg_capture.sv
// Testbench for sevenseg_capture: directed scenarios plus random phases
// compared every cycle against a sample-history reference model.
module tb_sevenseg_capture;

    localparam int SETTLE = 4;
    localparam int STABLE = 3;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       enable1;
    logic       enable2;
    logic [6:0] seg;
    logic       segerr_clr;
    logic [3:0] digit1;
    logic [3:0] digit2;
    logic       valid1;
    logic       valid2;
    logic       update;
    logic       update_sel;
    logic       segerr;

    always #5 clk = ~clk;

    sevenseg_capture #(.SETTLE(SETTLE), .STABLE(STABLE)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .enable1    (enable1),
        .enable2    (enable2),
        .seg        (seg),
        .segerr_clr (segerr_clr),
        .digit1     (digit1),
        .digit2     (digit2),
        .valid1     (valid1),
        .valid2     (valid2),
        .update     (update),
        .update_sel (update_sel),
        .segerr     (segerr)
    );

    int n_chk  = 0;
    int n_fail = 0;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp,
                     $time);
        end
    endtask

    logic [6:0] pat [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12,
                             7'h02, 7'h78, 7'h00, 7'h18, 7'h08, 7'h03,
                             7'h27, 7'h21, 7'h06, 7'h0E};

    function automatic int lookup(input logic [6:0] s);
        for (int i = 0; i < 16; i++) begin
            if (pat[i] == s) return i;
        end
        return -1;
    endfunction

    function automatic int phase_of(input logic e1, input logic e2);
        if (e2 && !e1) return 1;
        if (e1 && !e2) return 2;
        return 0;
    endfunction

    // Reference model: inputs delayed two edges, then per-interval sample list.
    logic [8:0] hist_q [$];
    int         m_ph;
    int         m_age;
    int         m_q [$];
    bit         m_done;
    int         m_dig [3];
    bit         m_val [3];
    bit         m_upd;
    bit         m_sel;
    bit         m_err;

    int         upd_cnt;
    logic       last_sel;

    task automatic model_reset();
        hist_q.delete();
        hist_q.push_back(9'h0);
        hist_q.push_back(9'h0);
        m_ph   = 0;
        m_age  = 0;
        m_q.delete();
        m_done = 0;
        m_dig  = '{0, 0, 0};
        m_val  = '{0, 0, 0};
        m_upd  = 0;
        m_sel  = 0;
        m_err  = 0;
    endtask

    task automatic model_edge();
        logic [8:0] s;
        int         p;
        int         v;
        bit         bad;
        bit         ok;
        s = hist_q.pop_front();
        hist_q.push_back({enable1, enable2, seg});
        p     = phase_of(s[8], s[7]);
        bad   = 0;
        m_upd = 0;
        if (p != m_ph) begin
            m_ph   = p;
            m_age  = 0;
            m_q.delete();
            m_done = 0;
        end else begin
            if (m_age <= SETTLE) m_age++;
            if (m_ph != 0 && !m_done && m_age > SETTLE) begin
                v = lookup(s[6:0]);
                m_q.push_back(v);
                bad = (v < 0);
                if (v >= 0 && m_q.size() >= STABLE) begin
                    ok = 1;
                    for (int i = 0; i < STABLE; i++) begin
                        if (m_q[m_q.size() - 1 - i] != v) ok = 0;
                    end
                    if (ok) begin
                        m_upd = (m_dig[m_ph] != v) || !m_val[m_ph];
                        m_sel = (m_ph == 2);
                        m_dig[m_ph] = v;
                        m_val[m_ph] = 1;
                        m_done = 1;
                    end
                end
            end
        end
        if (bad) m_err = 1;
        else if (segerr_clr) m_err = 0;
    endtask

    task automatic tick();
        logic [11:0] got;
        logic [11:0] exp;
        @(posedge clk);
        model_edge();
        #1;
        got = {digit1, digit2, valid1, valid2, update, segerr};
        exp = {4'(m_dig[1]), 4'(m_dig[2]), m_val[1], m_val[2], m_upd, m_err};
        check("cycle", 32'(got), 32'(exp));
        if (m_upd) check("upd_sel", 32'(update_sel), 32'(m_sel));
        if (update) begin
            upd_cnt++;
            last_sel = update_sel;
        end
    endtask

    task automatic run(input int n);
        repeat (n) tick();
    endtask

    task automatic drive(input int ph, input logic [6:0] s);
        enable1 = (ph == 2) || (ph == 3);
        enable2 = (ph == 1) || (ph == 3);
        seg     = s;
    endtask

    task automatic async_reset(input string tag);
        #3;
        reset_n = 1'b0;
        #1;
        check(tag, 32'({digit1, digit2, valid1, valid2, update, update_sel,
                        segerr}), 32'd0);
        model_reset();
        #2;
        reset_n = 1'b1;
    endtask

    initial begin
        int ph;
        int base;
        int len;
        int r;
        logic [6:0] s;

        reset_n    = 1'b0;
        segerr_clr = 1'b0;
        upd_cnt    = 0;
        last_sel   = 1'b0;
        drive(0, 7'h7F);
        model_reset();
        #2;
        check("reset", 32'({digit1, digit2, valid1, valid2, update,
                            update_sel, segerr}), 32'd0);
        #20;
        reset_n = 1'b1;

        // Short P2 burst: two samples only, then NONE.
        run(5);
        upd_cnt = 0;
        drive(2, 7'h24);
        run(SETTLE + 3);
        drive(0, 7'h24);
        run(10);
        check("short_valid2", 32'(valid2), 32'd0);
        check("short_upd", 32'(upd_cnt), 32'd0);

        // P1 steady 3.
        upd_cnt = 0;
        drive(1, 7'h30);
        run(20);
        check("p1_digit1", 32'(digit1), 32'h3);
        check("p1_valid1", 32'(valid1), 32'd1);
        check("p1_upd", 32'(upd_cnt), 32'd1);
        check("p1_sel", 32'(last_sel), 32'd0);
        check("p1_valid2", 32'(valid2), 32'd0);

        // Alternating P1=4 / P2=F.
        drive(0, 7'h7F);
        run(5);
        for (int k = 0; k < 2; k++) begin
            upd_cnt = 0;
            drive(1, 7'h19);
            run(64);
            drive(2, 7'h0E);
            run(64);
            check("alt_upd", 32'(upd_cnt), (k == 0) ? 32'd2 : 32'd0);
        end
        check("alt_digit1", 32'(digit1), 32'h4);
        check("alt_digit2", 32'(digit2), 32'hF);
        check("alt_valid2", 32'(valid2), 32'd1);

        // Blank pattern sets segerr, no commit; clear and set-wins.
        drive(0, 7'h7F);
        run(5);
        upd_cnt = 0;
        drive(1, 7'h7F);
        run(15);
        check("blank_err", 32'(segerr), 32'd1);
        check("blank_digit1", 32'(digit1), 32'h4);
        check("blank_upd", 32'(upd_cnt), 32'd0);
        drive(0, 7'h7F);
        run(5);
        check("err_sticky", 32'(segerr), 32'd1);
        segerr_clr = 1'b1;
        tick();
        check("err_clr", 32'(segerr), 32'd0);
        drive(1, 7'h7F);
        run(SETTLE + 3);
        check("err_clr_hold", 32'(segerr), 32'd0);
        tick();
        check("err_set_wins", 32'(segerr), 32'd1);
        segerr_clr = 1'b0;
        drive(0, 7'h7F);
        run(5);

        // Glitch 02,02,00,02,02,02 -> 6 only after the last three.
        upd_cnt = 0;
        drive(1, 7'h02);
        run(SETTLE + 3);
        drive(1, 7'h00);
        run(1);
        drive(1, 7'h02);
        run(4);
        check("glitch_pre", 32'(digit1), 32'h4);
        check("glitch_pre_upd", 32'(upd_cnt), 32'd0);
        run(1);
        check("glitch_digit1", 32'(digit1), 32'h6);
        check("glitch_upd", 32'(update), 32'd1);

        // Reset mid-SAMPLE with 9 stored, then recapture.
        drive(0, 7'h7F);
        run(5);
        drive(1, 7'h18);
        run(20);
        check("pre_rst_digit1", 32'(digit1), 32'h9);
        drive(0, 7'h18);
        run(5);
        drive(1, 7'h18);
        run(SETTLE + 4);
        async_reset("mid_rst");
        run(2 + SETTLE + STABLE);
        check("rst_no_early", 32'(valid1), 32'd0);
        run(1);
        check("rst_recap_digit1", 32'(digit1), 32'h9);
        check("rst_recap_valid1", 32'(valid1), 32'd1);
        check("rst_recap_upd", 32'(update), 32'd1);

        // Random phases with mostly-steady patterns.
        for (int b = 0; b < 150; b++) begin
            if ($urandom_range(0, 24) == 0) async_reset("rand_rst");
            ph   = $urandom_range(0, 3);
            base = $urandom_range(0, 15);
            len  = $urandom_range(1, 30);
            for (int c = 0; c < len; c++) begin
                r = $urandom_range(0, 99);
                if (r < 80) s = pat[base];
                else if (r < 90) s = pat[$urandom_range(0, 15)];
                else s = 7'($urandom_range(0, 127));
                drive(ph, s);
                segerr_clr = ($urandom_range(0, 9) == 0);
                tick();
            end
        end
        segerr_clr = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
